step_ctrl: RTL and testbench
============================

// Module: step_ctrl
// PURPOSE
//  Sits directly downstream of the clock divider. Converts the divider's slow
//  square wave, or a debounced STEP pushbutton, into one-Clk-cycle enable
//  pulses (CpuEn) for the single-cycle matrix processor.
//  Everything runs on the 100 MHz board clock, with no derived clock nets.
//  Also counts executed processor cycles for display and debug.
// PARAMETERS
//  DebounceCnt  1000000  Clk cycles the button must be stable (10 ms @100 MHz); >=2
//  CntW         16       width of CycleCnt
// PORTS
//  Clk       in   1     board clock, 100 MHz
//  Rst       in   1     synchronous reset, active-high
//  ClkDivIn  in   1     slow square wave from the clock divider (asynchronous to Clk)
//  BtnStep   in   1     raw STEP pushbutton, active-high, bouncy
//  RunMode   in   1     switch: 1 = free-run from ClkDivIn, 0 = single-step from BtnStep
//  Halt      in   1     processor halted (Clk domain); suppresses CpuEn
//  CpuEn     out  1     registered one-cycle processor enable pulse
//  CycleCnt  out  CntW  number of CpuEn pulses issued; wraps
//  DbState   out  3     debounce FSM state, for debug LEDs
// BEHAVIOUR
//  Reset (Rst=1 at posedge Clk): all synchronizer flops, CpuEn, CycleCnt and the
//   debounce counter clear to 0, and the FSM goes to IDLE. Rst dominates every
//   other input in that cycle.
//  Sync: ClkDivIn, BtnStep and RunMode each pass through a 2-flop synchronizer
//   (*_s). Halt is used unsynchronized.
//  Tick: tick = div_s & ~div_prev, where div_prev is a 1-flop delay of div_s.
//   This gives exactly one tick per ClkDivIn rising edge; falling edges are ignored.
//  Run-mode latency: ClkDivIn rises before edge E1, so CpuEn=1 in the cycle after E3.
//   That is 3 Clk edges, and the pulse width is exactly 1 cycle.
//  Debounce FSM (counter cnt, compare value DebounceCnt-1; DbState encoding in brackets):
//   IDLE(0):  btn_s=1 -> WAIT_PRESS, cnt=0.
//   WAIT_PRESS(1): btn_s=0 -> IDLE; cnt==DebounceCnt-1 -> PRESSED; else cnt+1.
//   PRESSED(2): step_req=1 for this single cycle -> HELD (unconditional).
//   HELD(3):  btn_s=0 -> WAIT_REL, cnt=0.
//   WAIT_REL(4): btn_s=1 -> HELD; cnt==DebounceCnt-1 -> IDLE; else cnt+1.
//   Result: exactly one step_req per stable press, regardless of hold length or bounce.
//   States 5-7 are illegal and recover to IDLE.
//  Enable: CpuEn <= (RunMode_s ? tick : step_req) & ~Halt.
//   Only the source selected by RunMode_s is used; the other is discarded and
//   never queued. The FSM keeps running in run mode.
//   Toggling RunMode never generates a pulse by itself.
//  Halt=1 drops the tick or step_req of that cycle; dropped events are not replayed.
//  CycleCnt: +1 in the cycle after each CpuEn=1 (i.e. counts pulses);
//   all-ones -> 0 wrap; frozen otherwise.
//  Reset mid-operation: a press in progress is abandoned and produces no pulse.
//   A button still held after reset is re-debounced from IDLE and then pulses once.
// TESTING (bench uses DebounceCnt=4, CntW=16)
//  1 Rst=1 for 2 cycles with all inputs=1 -> CpuEn=0, CycleCnt=0, DbState=0 during and after.
//  2 RunMode=1, ClkDivIn period 20 cycles, 5 rising edges -> 5 CpuEn pulses, each 1 cycle
//    wide, each 3 edges after its rise; CycleCnt=5.
//  3 RunMode=0, BtnStep 1,0,1,0 (2 cycles each), then 1 for 12 cycles, then bounce on
//    release, then 0 -> exactly 1 CpuEn pulse; DbState ends 0; ClkDivIn toggling meanwhile
//    gives no pulses.
//  4 RunMode=1, Halt=1 across 3 ticks -> CpuEn stays 0, CycleCnt unchanged.
//    Halt=0 -> the next tick pulses.
//  5 RunMode=1, ClkDivIn period 8 cycles for 65537 rises -> CycleCnt wraps to 1.
//  6 RunMode=0, Rst pulse while DbState=1 -> no pulse; button held -> one pulse after re-debounce.

Source files
------------

// File: rtl/step_ctrl_if.sv
// Control/status bundle between the step controller and its surroundings:
// clock-divider input, STEP button, mode/halt inputs, enable pulse and debug outputs.
interface step_ctrl_if #(
    parameter int CntW = 16
);
    logic            ClkDivIn;
    logic            BtnStep;
    logic            RunMode;
    logic            Halt;
    logic            CpuEn;
    logic [CntW-1:0] CycleCnt;
    logic [2:0]      DbState;

    modport master (
        output ClkDivIn, BtnStep, RunMode, Halt,
        input  CpuEn, CycleCnt, DbState
    );

    modport slave (
        input  ClkDivIn, BtnStep, RunMode, Halt,
        output CpuEn, CycleCnt, DbState
    );
endinterface

// File: rtl/step_ctrl.sv
// Turns the divider's slow square wave or a debounced STEP button into
// one-Clk-cycle processor enables, and counts the enables issued.
module step_ctrl #(
    parameter int DebounceCnt = 1000000,
    parameter int CntW        = 16
) (
    input logic       Clk,
    input logic       Rst,
    step_ctrl_if.slave Bus
);
    localparam int                  CntBits = (DebounceCnt > 2) ? $clog2(DebounceCnt) : 1;
    localparam logic [CntBits-1:0]  CntMax  = CntBits'(DebounceCnt - 1);

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        WaitPress = 3'd1,
        Pressed   = 3'd2,
        Held      = 3'd3,
        WaitRel   = 3'd4
    } dbState_t;

    // Bit order: 0 = ClkDivIn, 1 = BtnStep, 2 = RunMode
    logic [2:0] asyncIn;
    logic [2:0] syncMetaReg;
    logic [2:0] syncOutReg;

    assign asyncIn = {Bus.RunMode, Bus.BtnStep, Bus.ClkDivIn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gSync
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    syncMetaReg[gi] <= 1'b0;
                    syncOutReg[gi]  <= 1'b0;
                end else begin
                    syncMetaReg[gi] <= asyncIn[gi];
                    syncOutReg[gi]  <= syncMetaReg[gi];
                end
            end
        end
    endgenerate

    logic divS;
    logic btnS;
    logic runS;

    assign divS = syncOutReg[0];
    assign btnS = syncOutReg[1];
    assign runS = syncOutReg[2];

    dbState_t           stateReg;
    logic [CntBits-1:0] dbCntReg;
    logic               stepReq;

    // The counter is reused for both the press and the release qualification.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= Idle;
            dbCntReg <= '0;
        end else begin
            case (stateReg)
                Idle: begin
                    if (btnS) begin
                        stateReg <= WaitPress;
                        dbCntReg <= '0;
                    end
                end
                WaitPress: begin
                    if (!btnS) begin
                        stateReg <= Idle;
                    end else if (dbCntReg == CntMax) begin
                        stateReg <= Pressed;
                    end else begin
                        dbCntReg <= dbCntReg + CntBits'(1);
                    end
                end
                Pressed: begin
                    stateReg <= Held;
                end
                Held: begin
                    if (!btnS) begin
                        stateReg <= WaitRel;
                        dbCntReg <= '0;
                    end
                end
                WaitRel: begin
                    if (btnS) begin
                        stateReg <= Held;
                    end else if (dbCntReg == CntMax) begin
                        stateReg <= Idle;
                    end else begin
                        dbCntReg <= dbCntReg + CntBits'(1);
                    end
                end
                default: begin
                    stateReg <= Idle;
                end
            endcase
        end
    end

    assign stepReq = (stateReg == Pressed);

    logic            divPrevReg;
    logic            tick;
    logic            cpuEnReg;
    logic [CntW-1:0] cycleCntReg;

    assign tick = divS & ~divPrevReg;

    // Halt is already in the Clk domain; the unselected source is simply dropped.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            divPrevReg  <= 1'b0;
            cpuEnReg    <= 1'b0;
            cycleCntReg <= '0;
        end else begin
            divPrevReg <= divS;
            cpuEnReg   <= (runS ? tick : stepReq) & ~Bus.Halt;
            if (cpuEnReg) begin
                cycleCntReg <= cycleCntReg + CntW'(1);
            end
        end
    end

    assign Bus.CpuEn    = cpuEnReg;
    assign Bus.CycleCnt = cycleCntReg;
    assign Bus.DbState  = stateReg;
endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: reset, free-run ticks, debounced stepping,
// halt suppression, counter wrap and reset during a press.
module tb_step_ctrl;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    step_ctrl_if #(.CntW(16)) bus ();
    // A narrow counter instance keeps the wrap-around scenario short.
    step_ctrl_if #(.CntW(8))  wbus ();

    step_ctrl #(.DebounceCnt(4), .CntW(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (bus)
    );

    step_ctrl #(.DebounceCnt(4), .CntW(8)) dutWrap (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (wbus)
    );

    int nCompared   = 0;
    int nMismatched = 0;
    int expCnt      = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        bus.ClkDivIn = 1'b1; bus.BtnStep = 1'b1; bus.RunMode = 1'b1; bus.Halt = 1'b1;
        wbus.ClkDivIn = 1'b1; wbus.BtnStep = 1'b1; wbus.RunMode = 1'b1; wbus.Halt = 1'b1;
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            nCompared++;
            if (bus.CpuEn !== 1'b0) begin
                nMismatched++;
                $display("FAIL reset_cpuen cycle %0d: got %b want 0", i, bus.CpuEn);
            end
            nCompared++;
            if (bus.CycleCnt !== 16'd0) begin
                nMismatched++;
                $display("FAIL reset_cyclecnt cycle %0d: got %0d want 0", i, bus.CycleCnt);
            end
            nCompared++;
            if (bus.DbState !== 3'd0) begin
                nMismatched++;
                $display("FAIL reset_dbstate cycle %0d: got %0d want 0", i, bus.DbState);
            end
        end
        Rst = 1'b0;
        bus.ClkDivIn = 1'b0; bus.BtnStep = 1'b0; bus.RunMode = 1'b0; bus.Halt = 1'b0;
        wbus.ClkDivIn = 1'b0; wbus.BtnStep = 1'b0; wbus.RunMode = 1'b1; wbus.Halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            nCompared++;
            if ({bus.CpuEn, bus.CycleCnt, bus.DbState} !== 20'd0) begin
                nMismatched++;
                $display("FAIL after_reset cycle %0d: got CpuEn=%b CycleCnt=%0d DbState=%0d want all 0",
                         i, bus.CpuEn, bus.CycleCnt, bus.DbState);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_run_mode();
        bit expEn;
        bus.RunMode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nCompared++;
            if (bus.CpuEn !== 1'b0) begin
                nMismatched++;
                $display("FAIL mode_switch_pulse cycle %0d: got %b want 0", i, bus.CpuEn);
            end
        end
        for (int c = 0; c < 100; c++) begin
            bus.ClkDivIn = ((c % 20) < 10);
            step();
            expEn = ((c % 20) == 2);
            if (expEn) expCnt++;
            nCompared++;
            if (bus.CpuEn !== expEn) begin
                nMismatched++;
                $display("FAIL run_cpuen cycle %0d: got %b want %b", c, bus.CpuEn, expEn);
            end
        end
        nCompared++;
        if (bus.CycleCnt !== 16'd5) begin
            nMismatched++;
            $display("FAIL run_cyclecnt: got %0d want 5", bus.CycleCnt);
        end
        $display("test_run_mode: CycleCnt=%0d", bus.CycleCnt);
    endtask

    task automatic test_single_step();
        bit btnSeq [$];
        int pulses   = 0;
        int pulseIdx = -1;
        int n;
        bus.ClkDivIn = 1'b0;
        bus.RunMode  = 1'b0;
        for (int i = 0; i < 3; i++) step();
        btnSeq = '{1,0,1,0};
        n = 0;
        for (int i = 0; i < 4; i++) begin
            btnSeq.push_back(1'b0);
            btnSeq.push_back(1'b0);
        end
        btnSeq.delete();
        btnSeq = '{1,1,0,0,1,1,0,0};
        for (int i = 0; i < 12; i++) btnSeq.push_back(1'b1);
        btnSeq.push_back(1'b0); btnSeq.push_back(1'b1); btnSeq.push_back(1'b0);
        btnSeq.push_back(1'b1); btnSeq.push_back(1'b0);
        for (int i = 0; i < 12; i++) btnSeq.push_back(1'b0);
        n = btnSeq.size();
        for (int i = 0; i < n; i++) begin
            bus.BtnStep  = btnSeq[i];
            bus.ClkDivIn = (i < n - 12) ? (((i / 3) % 2) == 1) : 1'b0;
            step();
            if (bus.CpuEn === 1'b1) begin
                pulses++;
                pulseIdx = i;
            end
            if (i == 19) begin
                nCompared++;
                if (bus.DbState !== 3'd3) begin
                    nMismatched++;
                    $display("FAIL step_held_state: got %0d want 3", bus.DbState);
                end
            end
        end
        expCnt++;
        nCompared++;
        if (pulses !== 1) begin
            nMismatched++;
            $display("FAIL step_pulse_count: got %0d want 1", pulses);
        end
        nCompared++;
        if (pulseIdx !== 15) begin
            nMismatched++;
            $display("FAIL step_pulse_cycle: got %0d want 15", pulseIdx);
        end
        nCompared++;
        if (bus.DbState !== 3'd0) begin
            nMismatched++;
            $display("FAIL step_final_state: got %0d want 0", bus.DbState);
        end
        nCompared++;
        if (bus.CycleCnt !== 16'(expCnt)) begin
            nMismatched++;
            $display("FAIL step_cyclecnt: got %0d want %0d", bus.CycleCnt, expCnt);
        end
        $display("test_single_step: pulses=%0d at cycle %0d", pulses, pulseIdx);
    endtask

    task automatic test_halt();
        bit expEn;
        bus.ClkDivIn = 1'b0;
        bus.Halt     = 1'b1;
        bus.RunMode  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        for (int c = 0; c < 60; c++) begin
            bus.ClkDivIn = ((c % 20) < 10);
            step();
            nCompared++;
            if (bus.CpuEn !== 1'b0) begin
                nMismatched++;
                $display("FAIL halt_cpuen cycle %0d: got %b want 0", c, bus.CpuEn);
            end
        end
        nCompared++;
        if (bus.CycleCnt !== 16'(expCnt)) begin
            nMismatched++;
            $display("FAIL halt_cyclecnt: got %0d want %0d", bus.CycleCnt, expCnt);
        end
        bus.Halt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.ClkDivIn = ((c % 20) < 10);
            step();
            expEn = (c == 2);
            if (expEn) expCnt++;
            nCompared++;
            if (bus.CpuEn !== expEn) begin
                nMismatched++;
                $display("FAIL unhalt_cpuen cycle %0d: got %b want %b", c, bus.CpuEn, expEn);
            end
        end
        nCompared++;
        if (bus.CycleCnt !== 16'(expCnt)) begin
            nMismatched++;
            $display("FAIL unhalt_cyclecnt: got %0d want %0d", bus.CycleCnt, expCnt);
        end
        $display("test_halt: CycleCnt=%0d", bus.CycleCnt);
    endtask

    task automatic test_wrap();
        logic [7:0] wExp = 8'd0;
        for (int r = 0; r < 257; r++) begin
            for (int c = 0; c < 8; c++) begin
                wbus.ClkDivIn = (c < 4);
                step();
                if (c == 2) wExp = wExp + 8'd1;
            end
            nCompared++;
            if (wbus.CycleCnt !== wExp) begin
                nMismatched++;
                $display("FAIL wrap_cyclecnt rise %0d: got %0d want %0d", r + 1, wbus.CycleCnt, wExp);
            end
            if (r == 254) begin
                nCompared++;
                if (wbus.CycleCnt !== 8'hFF) begin
                    nMismatched++;
                    $display("FAIL wrap_allones: got %0d want 255", wbus.CycleCnt);
                end
            end
        end
        nCompared++;
        if (wbus.CycleCnt !== 8'd1) begin
            nMismatched++;
            $display("FAIL wrap_final: got %0d want 1", wbus.CycleCnt);
        end
        $display("test_wrap: CycleCnt=%0d", wbus.CycleCnt);
    endtask

    task automatic test_reset_mid_press();
        int pulses   = 0;
        int pulseIdx = -1;
        bus.RunMode  = 1'b0;
        bus.Halt     = 1'b0;
        bus.ClkDivIn = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.BtnStep = 1'b1;
        for (int i = 0; i < 3; i++) step();
        nCompared++;
        if (bus.DbState !== 3'd1) begin
            nMismatched++;
            $display("FAIL midpress_state: got %0d want 1", bus.DbState);
        end
        Rst = 1'b1;
        step();
        nCompared++;
        if ({bus.CpuEn, bus.CycleCnt, bus.DbState} !== 20'd0) begin
            nMismatched++;
            $display("FAIL midpress_reset: got CpuEn=%b CycleCnt=%0d DbState=%0d want all 0",
                     bus.CpuEn, bus.CycleCnt, bus.DbState);
        end
        Rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.CpuEn === 1'b1) begin
                pulses++;
                pulseIdx = i;
            end
        end
        nCompared++;
        if (pulses !== 1) begin
            nMismatched++;
            $display("FAIL redebounce_count: got %0d want 1", pulses);
        end
        nCompared++;
        if (pulseIdx !== 8) begin
            nMismatched++;
            $display("FAIL redebounce_cycle: got %0d want 8", pulseIdx);
        end
        nCompared++;
        if (bus.CycleCnt !== 16'd1) begin
            nMismatched++;
            $display("FAIL redebounce_cyclecnt: got %0d want 1", bus.CycleCnt);
        end
        bus.BtnStep = 1'b0;
        $display("test_reset_mid_press: pulses=%0d at cycle %0d", pulses, pulseIdx);
    endtask

    initial begin
        test_reset();
        test_run_mode();
        test_single_step();
        test_halt();
        test_wrap();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
